// File: rtl/exec_step_sequencer_pkg.sv
// Shared definitions for the EXEC/STEP execution-control front end.
// State encoding is fixed so the illegal code 2'd3 can be named and recovered from.
package exec_step_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [1:0] ST_ILLEGAL = 2'd3;

  // A clock-enable is granted to the core in every non-idle legal state.
  function automatic logic state_enables(input state_t st);
    return (st == ST_RUN) || (st == ST_STEP);
  endfunction

endpackage

// File: rtl/exec_step_sequencer_button_debouncer.sv
// Push-button conditioner: two-flop synchronizer, counted debounce and rising-edge detect.
// LEVEL is the debounced level; RISE is a one-cycle pulse when LEVEL goes 0 -> 1.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 5
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic BTN,
  output logic LEVEL,
  output logic RISE
);

  logic            sync_p0;
  logic            sync_p1;
  logic            stable;
  logic            stable_d;
  logic [DB_W-1:0] count;

  localparam logic [DB_W-1:0] COUNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Stage p0/p1: metastability chain for the asynchronous button.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= BTN;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: the level flips only after it has disagreed on DEBOUNCE_CYCLES consecutive edges.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      stable   <= 1'b0;
      stable_d <= 1'b0;
      count    <= '0;
    end else begin
      stable_d <= stable;
      if (sync_p1 != stable) begin
        if (count == COUNT_LAST) begin
          stable <= sync_p1;
          count  <= '0;
        end else begin
          count <= count + DB_W'(1);
        end
      end else begin
        count <= '0;
      end
    end
  end

  assign LEVEL = stable;
  assign RISE  = stable & ~stable_d;

endmodule

// File: rtl/exec_step_sequencer.sv
// RUN/STEP/IDLE sequencer driving the core clock-enable from debounced EXEC/STEP buttons.
// The core may end a free run through HALT; CYCLE_COUNT tallies enabled cycles.
module exec_step_sequencer
  import exec_step_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 5,
  parameter int CNT_W           = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             BTN_EXEC,
  input  logic             BTN_STEP,
  input  logic             HALT,
  output logic             EXEC,
  output logic             CLK_EN,
  output logic             RUNNING,
  output logic [CNT_W-1:0] CYCLE_COUNT
);

  logic   exec_level;
  logic   exec_rise;
  logic   step_level;
  logic   step_rise;
  logic   levels_unused;
  state_t state;
  state_t state_next;
  logic   clk_en_next;
  logic   running_next;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_exec_db (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .BTN  (BTN_EXEC),
    .LEVEL(exec_level),
    .RISE (exec_rise)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_step_db (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .BTN  (BTN_STEP),
    .LEVEL(step_level),
    .RISE (step_rise)
  );

  // Debounced levels are not needed by the sequencer; only the edges matter.
  assign levels_unused = exec_level ^ step_level;

  assign EXEC = exec_rise;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // HALT only blocks entry to RUN; a step is always allowed so the core can move past a halt.
  always_comb begin
    state_next   = state;
    clk_en_next  = 1'b0;
    running_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (exec_rise && !HALT) begin
          state_next = ST_RUN;
        end else if (step_rise) begin
          state_next = ST_STEP;
        end
      end
      ST_RUN: begin
        running_next = 1'b1;
        if (HALT || exec_rise) begin
          state_next = ST_IDLE;
        end
      end
      ST_STEP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    clk_en_next = state_enables(state);
  end

  // Enables decode straight from the state flops so the core gate sees no combinational glitch.
  assign CLK_EN  = clk_en_next;
  assign RUNNING = running_next;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      CYCLE_COUNT <= '0;
    end else if (CLK_EN) begin
      CYCLE_COUNT <= CYCLE_COUNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exec_step_sequencer.sv
// Directed bench for exec_step_sequencer with DEBOUNCE_CYCLES=4 and an 8-bit cycle counter.
// A press set just after edge 0 is first sampled at edge 1; EXEC pulses after edge 6 and state moves at edge 7.
module tb_exec_step_sequencer;

  localparam int D     = 4;
  localparam int CNT_W = 8;

  logic             CLOCK;
  logic             RESET;
  logic             BTN_EXEC;
  logic             BTN_STEP;
  logic             HALT;
  logic             EXEC;
  logic             CLK_EN;
  logic             RUNNING;
  logic [CNT_W-1:0] CYCLE_COUNT;

  int errors;
  int checks;

  exec_step_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .DB_W           (3),
    .CNT_W          (CNT_W)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .BTN_EXEC   (BTN_EXEC),
    .BTN_STEP   (BTN_STEP),
    .HALT       (HALT),
    .EXEC       (EXEC),
    .CLK_EN     (CLK_EN),
    .RUNNING    (RUNNING),
    .CYCLE_COUNT(CYCLE_COUNT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET    = 1'b1;
    BTN_EXEC = 1'b0;
    BTN_STEP = 1'b0;
    HALT     = 1'b0;
    tick(2);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET    = 1'b1;
    BTN_EXEC = 1'b0;
    BTN_STEP = 1'b0;
    HALT     = 1'b0;
    #1;
    checks++;
    if ({EXEC, CLK_EN, RUNNING} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got EXEC/CLK_EN/RUNNING=%b want 000", {EXEC, CLK_EN, RUNNING});
    end
    checks++;
    if (CYCLE_COUNT !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", CYCLE_COUNT);
    end
    tick(2);
    RESET = 1'b0;
    tick(3);
    checks++;
    if ({EXEC, CLK_EN, RUNNING, CYCLE_COUNT} !== 11'd0) begin
      errors++;
      $display("FAIL reset_idle_after_release: got %b want all zero", {EXEC, CLK_EN, RUNNING, CYCLE_COUNT});
    end
  endtask

  task automatic test_exec_run();
    int early;
    do_reset();
    BTN_EXEC = 1'b1;
    early = 0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      if (EXEC !== 1'b0 || CLK_EN !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL exec_early: got %0d early EXEC/CLK_EN cycles want 0", early);
    end
    tick(1);
    checks++;
    if ({EXEC, RUNNING, CLK_EN} !== 3'b100) begin
      errors++;
      $display("FAIL exec_pulse_edge6: got EXEC/RUNNING/CLK_EN=%b want 100", {EXEC, RUNNING, CLK_EN});
    end
    tick(1);
    checks++;
    if ({EXEC, RUNNING, CLK_EN} !== 3'b011 || CYCLE_COUNT !== 8'd0) begin
      errors++;
      $display("FAIL run_entry_edge7: got EXEC/RUNNING/CLK_EN=%b count=%0d want 011 count=0",
               {EXEC, RUNNING, CLK_EN}, CYCLE_COUNT);
    end
    tick(5);
    checks++;
    if (CYCLE_COUNT !== 8'd5) begin
      errors++;
      $display("FAIL run_count5: got %0d want 5", CYCLE_COUNT);
    end
    BTN_EXEC = 1'b0;
    early = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (EXEC !== 1'b0) early++;
    end
    checks++;
    if (early != 0 || RUNNING !== 1'b1 || CYCLE_COUNT !== 8'd13) begin
      errors++;
      $display("FAIL release_no_pulse: got pulses=%0d RUNNING=%b count=%0d want 0 1 13",
               early, RUNNING, CYCLE_COUNT);
    end
  endtask

  task automatic test_bounce();
    logic [15:0] pattern;
    int pulses;
    int pulse_at;
    pattern  = 16'b1111_1111_1111_0101;
    pulses   = 0;
    pulse_at = -1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      BTN_EXEC = pattern[i];
      tick(1);
      if (EXEC === 1'b1) begin
        pulses++;
        pulse_at = i + 1;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bounce_pulse_count: got %0d want 1", pulses);
    end
    checks++;
    if (pulse_at != 10) begin
      errors++;
      $display("FAIL bounce_pulse_edge: got %0d want 10", pulse_at);
    end
    checks++;
    if (RUNNING !== 1'b1) begin
      errors++;
      $display("FAIL bounce_run: got RUNNING=%b want 1", RUNNING);
    end
    BTN_EXEC = 1'b0;
    tick(8);
  endtask

  task automatic test_halt();
    do_reset();
    BTN_EXEC = 1'b1;
    tick(7);
    BTN_EXEC = 1'b0;
    tick(8);
    HALT = 1'b1;
    tick(1);
    checks++;
    if ({RUNNING, CLK_EN} !== 2'b00 || CYCLE_COUNT !== 8'd9) begin
      errors++;
      $display("FAIL halt_stop: got RUNNING/CLK_EN=%b count=%0d want 00 count=9", {RUNNING, CLK_EN}, CYCLE_COUNT);
    end
    HALT = 1'b0;
    tick(3);
    checks++;
    if (CYCLE_COUNT !== 8'd9 || CLK_EN !== 1'b0) begin
      errors++;
      $display("FAIL halt_freeze: got count=%0d CLK_EN=%b want 9 0", CYCLE_COUNT, CLK_EN);
    end
    HALT     = 1'b1;
    BTN_EXEC = 1'b1;
    tick(6);
    checks++;
    if (EXEC !== 1'b1) begin
      errors++;
      $display("FAIL halt_exec_pulse: got EXEC=%b want 1", EXEC);
    end
    tick(1);
    checks++;
    if ({RUNNING, CLK_EN} !== 2'b00 || CYCLE_COUNT !== 8'd9) begin
      errors++;
      $display("FAIL halt_blocks_run: got RUNNING/CLK_EN=%b count=%0d want 00 count=9",
               {RUNNING, CLK_EN}, CYCLE_COUNT);
    end
    BTN_EXEC = 1'b0;
    tick(8);
    HALT = 1'b0;
  endtask

  task automatic test_step();
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      HALT     = (pass == 1);
      BTN_STEP = 1'b1;
      tick(6);
      checks++;
      if (CLK_EN !== 1'b0) begin
        errors++;
        $display("FAIL step_early pass%0d: got CLK_EN=%b want 0", pass, CLK_EN);
      end
      tick(1);
      checks++;
      if ({CLK_EN, RUNNING} !== 2'b10 || CYCLE_COUNT !== 8'(pass)) begin
        errors++;
        $display("FAIL step_enable pass%0d: got CLK_EN/RUNNING=%b count=%0d want 10 count=%0d",
                 pass, {CLK_EN, RUNNING}, CYCLE_COUNT, pass);
      end
      tick(1);
      checks++;
      if (CLK_EN !== 1'b0 || CYCLE_COUNT !== 8'(pass + 1)) begin
        errors++;
        $display("FAIL step_single pass%0d: got CLK_EN=%b count=%0d want 0 count=%0d",
                 pass, CLK_EN, CYCLE_COUNT, pass + 1);
      end
      BTN_STEP = 1'b0;
      tick(8);
      checks++;
      if (CLK_EN !== 1'b0 || CYCLE_COUNT !== 8'(pass + 1)) begin
        errors++;
        $display("FAIL step_settle pass%0d: got CLK_EN=%b count=%0d want 0 count=%0d",
                 pass, CLK_EN, CYCLE_COUNT, pass + 1);
      end
    end
    HALT = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    BTN_EXEC = 1'b1;
    BTN_STEP = 1'b1;
    tick(7);
    checks++;
    if ({RUNNING, CLK_EN} !== 2'b11) begin
      errors++;
      $display("FAIL both_run_entry: got RUNNING/CLK_EN=%b want 11", {RUNNING, CLK_EN});
    end
    tick(1);
    checks++;
    if (RUNNING !== 1'b1 || CYCLE_COUNT !== 8'd1) begin
      errors++;
      $display("FAIL both_no_step: got RUNNING=%b count=%0d want 1 count=1", RUNNING, CYCLE_COUNT);
    end
    BTN_EXEC = 1'b0;
    BTN_STEP = 1'b0;
    tick(8);
    BTN_STEP = 1'b1;
    tick(7);
    checks++;
    if (RUNNING !== 1'b1 || CYCLE_COUNT !== 8'd16) begin
      errors++;
      $display("FAIL run_ignores_step: got RUNNING=%b count=%0d want 1 count=16", RUNNING, CYCLE_COUNT);
    end
    BTN_STEP = 1'b0;
    tick(8);
    BTN_EXEC = 1'b1;
    tick(7);
    checks++;
    if ({RUNNING, CLK_EN} !== 2'b00 || CYCLE_COUNT !== 8'd31) begin
      errors++;
      $display("FAIL exec_stops_run: got RUNNING/CLK_EN=%b count=%0d want 00 count=31",
               {RUNNING, CLK_EN}, CYCLE_COUNT);
    end
    BTN_EXEC = 1'b0;
    tick(8);
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    BTN_EXEC = 1'b1;
    tick(7);
    BTN_EXEC = 1'b0;
    tick(255);
    checks++;
    if (CYCLE_COUNT !== 8'd255) begin
      errors++;
      $display("FAIL count_preload: got %0d want 255", CYCLE_COUNT);
    end
    tick(1);
    checks++;
    if (CYCLE_COUNT !== 8'd0 || RUNNING !== 1'b1) begin
      errors++;
      $display("FAIL count_wrap: got count=%0d RUNNING=%b want 0 1", CYCLE_COUNT, RUNNING);
    end
    tick(3);
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if ({CLK_EN, RUNNING} !== 2'b00 || CYCLE_COUNT !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got CLK_EN/RUNNING=%b count=%0d want 00 count=0",
               {CLK_EN, RUNNING}, CYCLE_COUNT);
    end
    tick(2);
    RESET = 1'b0;
    tick(2);
    checks++;
    if ({CLK_EN, RUNNING} !== 2'b00 || CYCLE_COUNT !== 8'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got CLK_EN/RUNNING=%b count=%0d want 00 count=0",
               {CLK_EN, RUNNING}, CYCLE_COUNT);
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    RESET    = 1'b1;
    BTN_EXEC = 1'b0;
    BTN_STEP = 1'b0;
    HALT     = 1'b0;
    test_reset();
    test_exec_run();
    test_bounce();
    test_halt();
    test_step();
    test_back_to_back();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
